// File: rtl/max_pool_stream.sv
// max_pool_stream: streaming 2x2 / stride-2 max pooling over an IMG_W x IMG_H frame.
// Pixels arrive in raster order; one pooled maximum is emitted per 2x2 block, one cycle
// after that block's bottom-right pixel is accepted.
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-high reset
//   start      one-cycle pulse, begins a frame (ignored while busy)
//   in_valid   in_data carries a pixel this cycle
//   in_data    signed pixel, In_d_W bits
//   in_ready   block accepts a pixel this cycle (high exactly while running)
//   out_valid  one-cycle pulse, out_data holds a new pooled maximum
//   out_data   signed pooled maximum, held between pulses
//   busy       frame in progress
//   frame_done one-cycle pulse together with the last out_valid of a frame
module max_pool_stream #(
   parameter int In_d_W = 18,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic              in_valid,
   input  logic [In_d_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [In_d_W-1:0] out_data,
   output logic              busy,
   output logic              frame_done
);

   localparam int ColW = $clog2(IMG_W);
   localparam int RowW = $clog2(IMG_H);
   localparam int LbD  = IMG_W / 2;
   localparam int LbW  = (LbD > 1) ? $clog2(LbD) : 1;

   localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
   localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   logic [0:0]               state_q, state_d;
   logic [ColW-1:0]          col_q, col_d;
   logic [RowW-1:0]          row_q, row_d;
   logic signed [In_d_W-1:0] first_q, first_d;
   logic signed [In_d_W-1:0] out_data_q, out_data_d;
   logic                     out_valid_q, out_valid_d;
   logic                     frame_done_q, frame_done_d;

   // Horizontal maxima of the even row, one per output column; never reset.
   logic signed [In_d_W-1:0] linebuf_q [LbD];

   logic signed [In_d_W-1:0] pix, h_max, lb_rd, v_max;
   logic [LbW-1:0]           lb_idx;
   logic                     lb_we;
   logic                     accept;
   logic                     col_last, row_last;

   assign pix      = in_data;
   assign accept   = (state_q == StRun) && in_valid;
   assign col_last = (col_q == ColLast);
   assign row_last = (row_q == RowLast);
   assign lb_idx   = LbW'(col_q >> 1);
   assign lb_rd    = linebuf_q[lb_idx];
   assign h_max    = (pix > first_q) ? pix : first_q;
   assign v_max    = (lb_rd > h_max) ? lb_rd : h_max;

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      first_d      = first_q;
      out_data_d   = out_data_q;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      lb_we        = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               col_d   = '0;
               row_d   = '0;
            end
         end
         default: begin
            if (accept) begin
               if (!col_q[0]) begin
                  first_d = pix;
               end else if (!row_q[0]) begin
                  lb_we = 1'b1;
               end else begin
                  out_data_d   = v_max;
                  out_valid_d  = 1'b1;
                  frame_done_d = col_last && row_last;
               end
               if (col_last) begin
                  col_d = '0;
                  row_d = row_last ? '0 : row_q + RowW'(1);
               end else begin
                  col_d = col_q + ColW'(1);
               end
               if (col_last && row_last) begin
                  state_d = StIdle;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= StIdle;
         col_q        <= '0;
         row_q        <= '0;
         first_q      <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         first_q      <= first_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (lb_we) begin
         linebuf_q[lb_idx] <= h_max;
      end
   end

   assign in_ready   = (state_q == StRun);
   assign busy       = (state_q == StRun);
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_stream.sv
// Directed bench for max_pool_stream: a 4x4 instance for the hand-computed cases and a
// default 8x8 instance checked against a small reference model.
module tb_max_pool_stream;

   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // 4x4 instance
   logic              a_start = 1'b0, a_valid = 1'b0;
   logic [17:0]       a_data = '0;
   logic              a_ready, a_ovalid, a_busy, a_done;
   logic signed [17:0] a_odata;

   max_pool_stream #(.In_d_W(18), .IMG_W(4), .IMG_H(4)) dut_a (
      .clk       (clk),
      .clr       (clr),
      .start     (a_start),
      .in_valid  (a_valid),
      .in_data   (a_data),
      .in_ready  (a_ready),
      .out_valid (a_ovalid),
      .out_data  (a_odata),
      .busy      (a_busy),
      .frame_done(a_done)
   );

   // 8x8 instance (default size)
   logic              b_start = 1'b0, b_valid = 1'b0;
   logic [17:0]       b_data = '0;
   logic              b_ready, b_ovalid, b_busy, b_done;
   logic signed [17:0] b_odata;

   max_pool_stream dut_b (
      .clk       (clk),
      .clr       (clr),
      .start     (b_start),
      .in_valid  (b_valid),
      .in_data   (b_data),
      .in_ready  (b_ready),
      .out_valid (b_ovalid),
      .out_data  (b_odata),
      .busy      (b_busy),
      .frame_done(b_done)
   );

   // Output monitors, sampled on the falling edge.
   int qa_d[$], qa_c[$], exp_c[$], qb_d[$];
   int a_done_n = 0, a_done_c = -1, b_done_n = 0;

   always @(negedge clk) begin
      if (a_ovalid === 1'b1) begin
         qa_d.push_back(int'(a_odata));
         qa_c.push_back(cyc);
      end
      if (a_done === 1'b1) begin
         a_done_n++;
         a_done_c = cyc;
      end
      if (b_ovalid === 1'b1) qb_d.push_back(int'(b_odata));
      if (b_done === 1'b1) b_done_n++;
   end

   // Called at posedge+1. Optionally inserts an idle cycle before every pixel (stall) and
   // a start pulse with in_valid low before pixel mid_start.
   task automatic send_a(input int pix[16], input int n, input bit stall, input int mid_start);
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      check("a_busy_after_start", a_busy, 1);
      for (int i = 0; i < n; i++) begin
         if (stall) begin
            a_valid = 1'b0;
            @(posedge clk); #1;
         end
         if (i == mid_start) begin
            a_valid = 1'b0;
            a_start = 1'b1;
            @(posedge clk); #1;
            a_start = 1'b0;
            check("a_busy_mid_start", a_busy, 1);
         end
         a_valid = 1'b1;
         a_data  = 18'(pix[i]);
         // Bottom-right pixel of a block: result expected in the cycle after acceptance.
         if (((i / 4) % 2 == 1) && ((i % 4) % 2 == 1)) exp_c.push_back(cyc + 1);
         @(posedge clk); #1;
      end
      a_valid = 1'b0;
   endtask

   task automatic check_a(input string tag, input int ev[8], input int n, input int done_exp);
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_count"}, qa_d.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < qa_d.size()) begin
            check($sformatf("%s_data%0d", tag, i), qa_d[i], ev[i]);
            if (i < exp_c.size()) check($sformatf("%s_lat%0d", tag, i), qa_c[i], exp_c[i]);
         end
      end
      check({tag, "_done_n"}, a_done_n, done_exp);
      if (done_exp > 0 && n > 0 && exp_c.size() >= n)
         check({tag, "_done_cyc"}, a_done_c, exp_c[n-1]);
      check({tag, "_idle"}, a_busy, 0);
      qa_d.delete();
      qa_c.delete();
      exp_c.delete();
      a_done_n = 0;
   endtask

   int seq[16], rev[16], neg[16];
   int pixb[64];
   int refb[16];

   initial begin
      for (int i = 0; i < 16; i++) begin
         seq[i] = i;
         rev[i] = 15 - i;
         neg[i] = (i == 10) ? -1 : -3;
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", a_busy, 0);
      check("rst_ready", a_ready, 0);
      check("rst_ovalid", a_ovalid, 0);
      check("rst_odata", a_odata, 0);
      check("rst_done", a_done, 0);
      check("rst_b_busy", b_busy, 0);
      clr = 1'b0;
      @(posedge clk); #1;

      // in_valid while idle is ignored
      a_valid = 1'b1;
      a_data  = 18'd99;
      repeat (2) @(posedge clk);
      #1;
      a_valid = 1'b0;
      check("idle_valid_busy", a_busy, 0);
      check("idle_valid_out", qa_d.size(), 0);

      send_a(seq, 16, 1'b0, -1);
      check_a("basic", '{5, 7, 13, 15, 0, 0, 0, 0}, 4, 1);

      send_a(neg, 16, 1'b0, -1);
      check_a("neg", '{-3, -3, -3, -1, 0, 0, 0, 0}, 4, 1);

      send_a(seq, 16, 1'b1, -1);
      check_a("stall", '{5, 7, 13, 15, 0, 0, 0, 0}, 4, 1);

      // Reset mid-frame after pixel 9, asserted between clock edges
      send_a(seq, 10, 1'b0, -1);
      clr = 1'b1;
      #1;
      check("clr_async_busy", a_busy, 0);
      check("clr_async_ready", a_ready, 0);
      check("clr_async_odata", a_odata, 0);
      @(posedge clk); #1;
      clr = 1'b0;
      check_a("partial", '{5, 7, 0, 0, 0, 0, 0, 0}, 2, 0);
      send_a(seq, 16, 1'b0, -1);
      check_a("after_clr", '{5, 7, 13, 15, 0, 0, 0, 0}, 4, 1);

      send_a(seq, 16, 1'b0, 6);
      check_a("mid_start", '{5, 7, 13, 15, 0, 0, 0, 0}, 4, 1);

      send_a(seq, 16, 1'b0, -1);
      send_a(rev, 16, 1'b0, -1);
      check_a("b2b", '{5, 7, 13, 15, 15, 13, 7, 5}, 8, 2);

      // 8x8 random frame against a reference model, with both signed extremes present
      for (int i = 0; i < 64; i++) begin
         logic [17:0] r;
         r = 18'($urandom);
         pixb[i] = int'($signed(r));
      end
      pixb[0] = -131072;
      pixb[9] = 131071;
      pixb[18] = -131072;
      pixb[19] = -131072;
      pixb[26] = -131072;
      pixb[27] = -131072;
      for (int br = 0; br < 4; br++) begin
         for (int bc = 0; bc < 4; bc++) begin
            int m;
            m = pixb[(2 * br) * 8 + 2 * bc];
            if (pixb[(2 * br) * 8 + 2 * bc + 1] > m) m = pixb[(2 * br) * 8 + 2 * bc + 1];
            if (pixb[(2 * br + 1) * 8 + 2 * bc] > m) m = pixb[(2 * br + 1) * 8 + 2 * bc];
            if (pixb[(2 * br + 1) * 8 + 2 * bc + 1] > m) m = pixb[(2 * br + 1) * 8 + 2 * bc + 1];
            refb[br * 4 + bc] = m;
         end
      end
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      check("b_busy_after_start", b_busy, 1);
      for (int i = 0; i < 64; i++) begin
         b_valid = 1'b1;
         b_data  = 18'(pixb[i]);
         @(posedge clk); #1;
      end
      b_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("b_count", qb_d.size(), 16);
      for (int i = 0; i < 16; i++) begin
         if (i < qb_d.size()) check($sformatf("b_data%0d", i), qb_d[i], refb[i]);
      end
      check("b_done_n", b_done_n, 1);
      check("b_idle", b_busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
